// File: rtl/gameover_pkg.sv
// gameover_pkg: shared constants and types for the "GAME OVER!" text renderer.
//   CHAR_W / CHAR_H : glyph cell size in pixels
//   MSG             : 7-bit ASCII codes of the message, left to right
//   state_t         : reveal/blink controller states
//   msg_char()      : message lookup that returns a space outside the string
package gameover_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int MSG_LEN = 10;
  localparam int ROM_AW  = 11;  // {7-bit char code, 4-bit glyph row}

  localparam logic [6:0] MSG [MSG_LEN] = '{
    7'h47, 7'h41, 7'h4D, 7'h45, 7'h20,   // G A M E ' '
    7'h4F, 7'h56, 7'h45, 7'h52, 7'h21    // O V E R !
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    BLINK  = 2'd2
  } state_t;

  // Out-of-range indices map to a space, which never lights a pixel.
  function automatic logic [6:0] msg_char(input logic [6:0] idx);
    if (idx < 7'(MSG_LEN)) return MSG[idx[3:0]];
    return 7'h20;
  endfunction

endpackage

// File: rtl/gameover_text_render_font_rom.sv
// font_rom: 8x16 bitmap font for the glyphs used by the message.
//   Clk  : clock; read data is registered (1-cycle latency)
//   addr : {char_code[6:0], row[3:0]}
//   data : glyph row, bit 7 = leftmost pixel
// Characters not in the message (including space) read as all zeros.
module font_rom
  import gameover_pkg::*;
(
  input  logic              Clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        data
);

  // Row 0 occupies bits [127:120].
  function automatic logic [127:0] glyph_bits(input logic [6:0] code);
    case (code)
      7'h47:   return 128'h00003C66C2C0C0DEC6C6663A00000000;  // G
      7'h41:   return 128'h000010386CC6C6FEC6C6C6C600000000;  // A
      7'h4D:   return 128'h0000C6EEFEFED6C6C6C6C6C600000000;  // M
      7'h45:   return 128'h0000FE6662687868606266FE00000000;  // E
      7'h4F:   return 128'h00007CC6C6C6C6C6C6C6C67C00000000;  // O
      7'h56:   return 128'h0000C6C6C6C6C6C6C66C381000000000;  // V
      7'h52:   return 128'h0000FC6666667C6C666666E600000000;  // R
      7'h21:   return 128'h0000183C3C3C18181800181800000000;  // !
      default: return 128'h0;
    endcase
  endfunction

  logic [127:0] glyph;

  always_comb glyph = glyph_bits(addr[10:4]);

  // NOTE: ROM read data carries no reset; the visibility bit travelling with
  // it is reset instead, so stale data can never reach the output.
  always_ff @(posedge Clk) begin
    data <= glyph[8*(15 - int'(addr[3:0])) +: 8];
  end

endmodule

// File: rtl/gameover_text_render.sv
// gameover_text_render: reveals "GAME OVER!" one character at a time, then
// blinks it, and produces a per-pixel lit flag for the display scan.
//   Clk, Reset              : clock, synchronous active-high reset
//   frame_tick              : one-cycle pulse per video frame
//   game_over               : level, screen active while high
//   DrawX, DrawY            : current scan pixel
//   gametextX/Y             : top-left of the text box
//   gametextWidth/Height    : text box size
//   text_on                 : pixel is a lit glyph bit (3-cycle latency)
//   reveal_done             : high while blinking (reveal finished)
module gameover_text_render
  import gameover_pkg::*;
#(
  parameter int NUM_CHARS     = 10,
  parameter int REVEAL_FRAMES = 8,
  parameter int BLINK_HALF    = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] gametextX,
  input  logic [9:0] gametextY,
  input  logic [9:0] gametextWidth,
  input  logic [9:0] gametextHeight,
  output logic       text_on,
  output logic       reveal_done
);

  localparam int FRAME_MAX = (REVEAL_FRAMES > BLINK_HALF) ? REVEAL_FRAMES : BLINK_HALF;
  localparam int FCW       = $clog2(FRAME_MAX + 1);

  state_t         state, state_nxt;
  logic [FCW-1:0] frame_cnt, frame_cnt_nxt;
  logic [7:0]     reveal_cnt, reveal_cnt_nxt;
  logic           blink_on, blink_on_nxt;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      reveal_cnt <= '0;
      blink_on   <= 1'b1;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_cnt_nxt;
      reveal_cnt <= reveal_cnt_nxt;
      blink_on   <= blink_on_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    frame_cnt_nxt  = frame_cnt;
    reveal_cnt_nxt = reveal_cnt;
    blink_on_nxt   = blink_on;
    if (!game_over) begin
      state_nxt = IDLE;  // leaving the screen beats every other transition
    end else begin
      case (state)
        IDLE: begin
          // A frame_tick on the entry cycle is deliberately ignored.
          state_nxt      = REVEAL;
          frame_cnt_nxt  = '0;
          reveal_cnt_nxt = '0;
        end
        REVEAL: if (frame_tick) begin
          if (frame_cnt == FCW'(REVEAL_FRAMES - 1)) begin
            frame_cnt_nxt  = '0;
            reveal_cnt_nxt = reveal_cnt + 8'd1;
            if (reveal_cnt == 8'(NUM_CHARS - 1)) begin
              state_nxt    = BLINK;
              blink_on_nxt = 1'b1;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + FCW'(1);
          end
        end
        BLINK: if (frame_tick) begin
          if (frame_cnt == FCW'(BLINK_HALF - 1)) begin
            frame_cnt_nxt = '0;
            blink_on_nxt  = !blink_on;
          end else begin
            frame_cnt_nxt = frame_cnt + FCW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign reveal_done = (state == BLINK);

  // ---------------------------------------------------------- pixel path
  logic [10:0] x_end, y_end;
  logic [9:0]  rel_x, rel_y;
  logic [6:0]  char_idx;
  logic        in_box, vis_0;

  // 11-bit ends so a box reaching past coordinate 1023 does not wrap.
  assign x_end    = {1'b0, gametextX} + {1'b0, gametextWidth};
  assign y_end    = {1'b0, gametextY} + {1'b0, gametextHeight};
  assign rel_x    = DrawX - gametextX;
  assign rel_y    = DrawY - gametextY;
  assign char_idx = rel_x[9:3];

  always_comb begin
    in_box = (DrawX >= gametextX) && ({1'b0, DrawX} < x_end) &&
             (DrawY >= gametextY) && ({1'b0, DrawY} < y_end);
    vis_0  = in_box && ({1'b0, char_idx} < 8'(NUM_CHARS)) &&
             (rel_y < 10'(CHAR_H)) &&
             (((state == REVEAL) && ({1'b0, char_idx} < reveal_cnt)) ||
              ((state == BLINK) && blink_on));
  end

  logic              vis_1, vis_2;
  logic [2:0]        col_1, col_2;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vis_1   <= 1'b0;
      vis_2   <= 1'b0;
      text_on <= 1'b0;
    end else begin
      vis_1   <= vis_0;
      vis_2   <= vis_1;
      text_on <= vis_2 && rom_data[3'd7 - col_2];
    end
  end

  // Column and address are pure data; validity is carried by vis_*.
  always_ff @(posedge Clk) begin
    col_1    <= rel_x[2:0];
    col_2    <= col_1;
    rom_addr <= {msg_char(char_idx), rel_y[3:0]};
  end

  font_rom u_font_rom (
    .Clk  (Clk),
    .addr (rom_addr),
    .data (rom_data)
  );

endmodule

// File: tb/tb_gameover_text_render.sv
// Directed bench for gameover_text_render with hand-computed expectations.
module tb_gameover_text_render;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, game_over;
  logic [9:0] DrawX, DrawY, gametextX, gametextY, gametextWidth, gametextHeight;
  logic       text_on, reveal_done;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  gameover_text_render dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .game_over      (game_over),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .gametextX      (gametextX),
    .gametextY      (gametextY),
    .gametextWidth  (gametextWidth),
    .gametextHeight (gametextHeight),
    .text_on        (text_on),
    .reveal_done    (reveal_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // All helpers start and end on a falling edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic pix(input int x, input int y, output logic v);
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    v = text_on;
  endtask

  task automatic set_box(input int x, input int y, input int w, input int h);
    gametextX      = 10'(x);
    gametextY      = 10'(y);
    gametextWidth  = 10'(w);
    gametextHeight = 10'(h);
  endtask

  logic       v, lit;
  logic [7:0] g_row2;

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; game_over = 1'b0;
    DrawX = '0; DrawY = '0;
    set_box(300, 100, 80, 16);
    g_row2 = 8'h3C;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_text_on", text_on, 0);
    check("rst_reveal_done", reveal_done, 0);
    pix(302, 102, v); check("idle_dark", v, 0);

    // Entry with a coincident tick: that tick must not count.
    game_over = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    tick_n(7);
    pix(302, 102, v); check("tick7_g_hidden", v, 0);
    tick_n(1);
    pix(300, 100, v); check("g_row0_col0", v, 0);
    pix(302, 102, v); check("g_revealed", v, 1);
    pix(311, 103, v); check("a_hidden", v, 0);

    tick_n(71);
    check("done_at_79", reveal_done, 0);
    tick_n(1);
    check("done_at_80", reveal_done, 1);

    // Blink on-phase: box edges and lit interior pixels.
    pix(299, 100, v); check("edge_left", v, 0);
    pix(380, 100, v); check("edge_right", v, 0);
    pix(300, 99, v);  check("edge_top", v, 0);
    pix(300, 116, v); check("edge_bottom", v, 0);
    pix(302, 102, v); check("blink_g", v, 1);
    pix(311, 103, v); check("blink_a", v, 1);

    // One pixel per clock, exactly three cycles of latency.
    for (int i = 0; i < 11; i++) begin
      if (i >= 3) check($sformatf("stream_col%0d", i - 3), text_on, g_row2[7 - (i - 3)]);
      if (i < 8) begin
        DrawX = 10'(300 + i);
        DrawY = 10'd102;
      end
      @(negedge Clk);
    end

    lit = 1'b0;
    for (int y = 100; y < 116; y++)
      for (int x = 332; x < 340; x++) begin
        pix(x, y, v);
        lit |= v;
      end
    check("space_dark", lit, 0);

    // Box geometry: width boundary, moved box, height limit, no 11-bit wrap.
    set_box(300, 100, 64, 16); pix(364, 102, v); check("r_outside_w64", v, 0);
    set_box(300, 100, 65, 16); pix(364, 102, v); check("r_inside_w65", v, 1);
    set_box(300, 90, 80, 16);  pix(301, 100, v); check("g_row10_moved", v, 1);
    set_box(300, 86, 80, 30);  pix(301, 112, v); check("rel_y_ge16", v, 0);
    set_box(1000, 100, 100, 16); pix(1002, 102, v); check("no_wrap", v, 1);
    set_box(300, 100, 80, 16);

    // Blink timing.
    tick_n(31); pix(302, 102, v); check("blink_on_31", v, 1);
    tick_n(1);  pix(302, 102, v); check("blink_off_32", v, 0);
    check("done_in_off", reveal_done, 1);
    tick_n(31); pix(302, 102, v); check("blink_off_63", v, 0);
    tick_n(1);  pix(302, 102, v); check("blink_resume", v, 1);

    // Leave and restart, then drop mid-reveal.
    game_over = 1'b0;
    @(negedge Clk);
    check("drop_from_blink", reveal_done, 0);
    game_over = 1'b1;
    @(negedge Clk);
    tick_n(20);
    pix(311, 103, v); check("a_at20", v, 1);
    pix(316, 103, v); check("m_at20", v, 0);
    pix(302, 102, v); check("g_at20", v, 1);
    game_over = 1'b0;
    repeat (3) @(negedge Clk);
    check("drop_still_lit", text_on, 1);
    @(negedge Clk);
    check("drop_dark", text_on, 0);
    game_over = 1'b1;
    pix(302, 102, v); check("restart_dark", v, 0);
    tick_n(8);
    pix(302, 102, v); check("restart_g", v, 1);
    pix(311, 103, v); check("restart_a_hidden", v, 0);
    tick_n(72);
    check("done_again", reveal_done, 1);
    pix(302, 102, v); check("blink_again", v, 1);

    // Reset mid-blink overrides game_over and frame_tick.
    Reset = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; frame_tick = 1'b0;
    check("rst_blink_idle", reveal_done, 0);
    check("rst_blink_dark", text_on, 0);
    @(negedge Clk);
    tick_n(79);
    check("rst_done_at_79", reveal_done, 0);
    tick_n(1);
    check("rst_done_at_80", reveal_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
